// File: rtl/led_pwm_scan.sv
// Four-channel PWM LED driver. Once per PWM period it scans duty/control words
// from a synchronous RAM into a shadow copy and commits them at the next period boundary.
module led_pwm_scan #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int BASE_ADDR  = 0,
    parameter int PRESCALE   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic [3:0]            led,
    output logic                  busy
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {IDLE, REQ, CAP} state_t;

    state_t          state_reg, state_next;
    logic [2:0]      idx_reg, idx_next;
    logic [PW-1:0]   presc_reg;
    logic [7:0]      pwm_reg;
    logic            pending_reg;
    logic [3:0][7:0] shadow_duty_reg;
    logic [1:0]      shadow_ctrl_reg;
    logic [3:0][7:0] duty_reg;
    logic [1:0]      ctrl_reg;
    logic [3:0]      led_reg;
    logic [3:0]      led_next;

    logic tick;
    logic boundary;
    logic capture;
    logic scan_done;

    // Bits above the duty byte carry no meaning for this block.
    logic unused_rdata;
    assign unused_rdata = ^ram_rdata[DATA_WIDTH-1:8];

    assign tick     = (presc_reg == PW'(PRESCALE - 1));
    assign boundary = tick && (pwm_reg == 8'hFF);

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        capture    = 1'b0;
        scan_done  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (boundary) begin
                    state_next = REQ;
                    idx_next   = 3'd0;
                end
            end
            REQ: begin
                state_next = CAP;
            end
            CAP: begin
                capture = 1'b1;
                if (idx_reg < 3'd4) begin
                    idx_next   = idx_reg + 3'd1;
                    state_next = REQ;
                end else begin
                    idx_next   = 3'd0;
                    state_next = IDLE;
                    scan_done  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            idx_reg         <= 3'd0;
            presc_reg       <= '0;
            pwm_reg         <= 8'd0;
            pending_reg     <= 1'b0;
            shadow_duty_reg <= '0;
            shadow_ctrl_reg <= 2'b00;
            duty_reg        <= '0;
            ctrl_reg        <= 2'b00;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;

            if (tick) begin
                presc_reg <= '0;
                pwm_reg   <= pwm_reg + 8'd1;
            end else begin
                presc_reg <= presc_reg + PW'(1);
            end

            if (capture) begin
                if (idx_reg == 3'd4) begin
                    shadow_ctrl_reg <= ram_rdata[1:0];
                end else begin
                    shadow_duty_reg[idx_reg[1:0]] <= ram_rdata[7:0];
                end
            end

            // Commit consumes the previous scan; the scan starting on this
            // same edge refills the shadow for the following period.
            if (boundary && pending_reg) begin
                duty_reg    <= shadow_duty_reg;
                ctrl_reg    <= shadow_ctrl_reg;
                pending_reg <= 1'b0;
            end else if (scan_done) begin
                pending_reg <= 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_chan
            assign led_next[gi] = (ctrl_reg[0] & (pwm_reg < duty_reg[gi])) ^ ctrl_reg[1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            led_reg <= 4'b0000;
        end else begin
            led_reg <= led_next;
        end
    end

    assign led      = led_reg;
    assign busy     = (state_reg != IDLE);
    assign ram_cs   = (state_reg == REQ);
    assign ram_oe   = (state_reg == REQ);
    assign ram_we   = 1'b0;
    assign ram_addr = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(idx_reg);

endmodule

// File: tb/tb_led_pwm_scan.sv
// Bench for led_pwm_scan: table of register sets with measured duty counts,
// hand sequences for bus timing, glitch-free update and reset mid-scan, and
// random register traffic checked against a per-cycle arithmetic model.
module tb_led_pwm_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cs1, we1, oe1, busy1;
    logic [3:0]  addr1, led1;
    logic [15:0] rdata1;
    logic        cs3, we3, oe3, busy3;
    logic [3:0]  addr3, led3;
    logic [15:0] rdata3;

    logic [15:0] mem  [0:15];
    logic [15:0] mem3 [0:15];

    led_pwm_scan #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .BASE_ADDR(0), .PRESCALE(1)) dut1 (
        .clk(clk), .rst(rst), .ram_cs(cs1), .ram_we(we1), .ram_oe(oe1),
        .ram_addr(addr1), .ram_rdata(rdata1), .led(led1), .busy(busy1)
    );

    // Second instance: base address wraps past the top of the address space.
    led_pwm_scan #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .BASE_ADDR(14), .PRESCALE(3)) dut3 (
        .clk(clk), .rst(rst), .ram_cs(cs3), .ram_we(we3), .ram_oe(oe3),
        .ram_addr(addr3), .ram_rdata(rdata3), .led(led3), .busy(busy3)
    );

    always @(posedge clk) if (cs1 && oe1 && !we1) rdata1 <= mem[addr1];
    always @(posedge clk) if (cs3 && oe3 && !we3) rdata3 <= mem3[addr3];

    // Edges seen with reset low since the last reset edge.
    int unsigned n;
    always @(posedge clk) n <= rst ? 0 : n + 1;

    int checks   = 0;
    int failures = 0;
    bit model_on = 1'b0;
    bit d3_done  = 1'b0;
    int cnt [4];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_n(input int unsigned target);
        int g;
        g = 0;
        while (n != target) begin
            step();
            g++;
            if (g > 20000) begin
                checks++;
                failures++;
                $display("FAIL wait_n actual=%0d required=%0d", n, target);
                break;
            end
        end
    endtask

    task automatic count_period();
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        for (int t = 0; t < 256; t++) begin
            step();
            for (int i = 0; i < 4; i++) cnt[i] += int'(led1[i]);
        end
    endtask

    // Reference model for dut1 (PRESCALE=1, period 256 clk): registers seen
    // at each period boundary become active one period later.
    logic [7:0] snap_duty [0:127][0:3];
    logic [1:0] snap_ctrl [0:127];

    initial begin
        int unsigned m, p, pw, off, k;
        logic [3:0] exp_led;
        logic [1:0] ctl;
        logic [7:0] d;
        logic exp_busy, exp_cs;
        logic [7:0] act_bus, exp_bus;
        forever begin
            @(negedge clk);
            if (model_on) begin
                if (n != 0 && n % 256 == 0) begin
                    k = (n / 256) % 128;
                    for (int i = 0; i < 4; i++) snap_duty[k][i] = mem[i][7:0];
                    snap_ctrl[k] = mem[4][1:0];
                end
                exp_led = 4'b0000;
                if (n != 0) begin
                    m  = n - 1;
                    p  = m / 256;
                    pw = m % 256;
                    ctl = (p >= 2) ? snap_ctrl[(p - 1) % 128] : 2'b00;
                    for (int i = 0; i < 4; i++) begin
                        d = (p >= 2) ? snap_duty[(p - 1) % 128][i] : 8'd0;
                        exp_led[i] = (ctl[0] && (pw < d)) ^ ctl[1];
                    end
                end
                off      = n % 256;
                exp_busy = (n >= 256) && (off < 10);
                exp_cs   = exp_busy && (off % 2 == 0);
                act_bus  = {busy1, cs1, oe1, we1, (exp_cs || n == 0) ? addr1 : 4'd0};
                exp_bus  = {exp_busy, exp_cs, exp_cs, 1'b0, exp_cs ? 4'(off / 2) : 4'd0};
                check($sformatf("model_led n=%0d", n), int'(led1), int'(exp_led));
                check($sformatf("model_bus n=%0d", n), int'(act_bus), int'(exp_bus));
            end
        end
    end

    // dut3: duty word 0xAB20 -> 32 ticks x 3 clk = 96 clk of 768 in period 2.
    initial begin
        int c0, crest;
        c0 = 0;
        crest = 0;
        forever begin
            @(negedge clk);
            if (model_on && !d3_done && n >= 1537 && n <= 2304) begin
                c0 += int'(led3[0]);
                crest += int'(led3[1]) + int'(led3[2]) + int'(led3[3]);
                if (n == 2304) begin
                    check("p3_mask_width", c0, 96);
                    check("p3_other_ch", crest, 0);
                    d3_done = 1'b1;
                end
            end
        end
    end

    typedef struct packed {
        logic [3:0][15:0] duty;
        logic [15:0]      ctrl;
        logic [3:0][8:0]  exp_cnt;
    } vec_t;

    function automatic vec_t mk(input logic [15:0] d0, d1, d2, d3, c,
                                input int e0, e1, e2, e3);
        vec_t v;
        v.duty[0] = d0; v.duty[1] = d1; v.duty[2] = d2; v.duty[3] = d3;
        v.ctrl = c;
        v.exp_cnt[0] = 9'(e0); v.exp_cnt[1] = 9'(e1);
        v.exp_cnt[2] = 9'(e2); v.exp_cnt[3] = 9'(e3);
        return v;
    endfunction

    vec_t vecs [5];

    initial begin
        int unsigned p, b;
        logic [19:0] addr_seq;
        logic [10:0] cs_pat;
        int busy_cnt, cs_cnt;

        vecs[0] = mk(16'hAB20, 16'h0080, 16'h00C0, 16'h00FF, 16'h0001, 32, 128, 192, 255);
        vecs[1] = mk(16'h0040, 16'h0080, 16'h00C0, 16'h00FF, 16'h0001, 64, 128, 192, 255);
        vecs[2] = mk(16'h0040, 16'h0080, 16'h00C0, 16'h00FF, 16'h0000, 0, 0, 0, 0);
        vecs[3] = mk(16'h0000, 16'h000A, 16'h0014, 16'h001E, 16'h0003, 256, 246, 236, 226);
        vecs[4] = mk(16'h1210, 16'hFF00, 16'h0001, 16'h0180, 16'hFFFD, 16, 0, 1, 128);

        for (int i = 0; i < 16; i++) begin
            mem[i]  = 16'h0000;
            mem3[i] = 16'h0000;
        end
        mem3[14] = 16'hAB20;
        mem3[2]  = 16'h0001;

        rst = 1'b1;
        repeat (3) step();
        model_on = 1'b1;
        check("rst_led", int'(led1), 0);
        check("rst_busy", int'(busy1), 0);
        check("rst_cs_oe_we", int'({cs1, oe1, we1}), 0);
        check("rst_addr", int'(addr1), 0);
        check("rst_addr_p3", int'(addr3), 14);
        rst = 1'b0;

        // Register-set table: load mid-period, measure the period after commit.
        for (int v = 0; v < 5; v++) begin
            p = n / 256 + 1;
            wait_n(p * 256 + 128);
            for (int i = 0; i < 4; i++) mem[i] = vecs[v].duty[i];
            mem[4] = vecs[v].ctrl;
            wait_n((p + 2) * 256);
            count_period();
            for (int i = 0; i < 4; i++)
                check($sformatf("vec%0d_ch%0d_count", v, i), cnt[i], int'(vecs[v].exp_cnt[i]));
        end

        // Read strobe timing over one scan.
        wait_n((n / 256 + 1) * 256);
        addr_seq = '0;
        cs_pat   = '0;
        busy_cnt = 0;
        cs_cnt   = 0;
        for (int j = 0; j < 11; j++) begin
            cs_pat = {cs_pat[9:0], cs1};
            if (busy1) busy_cnt++;
            if (cs1) begin
                cs_cnt++;
                addr_seq = {addr_seq[15:0], addr1};
            end
            if (j == 10) check("scan_busy_end", int'(busy1), 0);
            step();
        end
        check("scan_busy_cycles", busy_cnt, 10);
        check("scan_cs_count", cs_cnt, 5);
        check("scan_cs_pattern", int'(cs_pat), int'(11'b10101010100));
        check("scan_addr_seq", int'(addr_seq), int'(20'h01234));

        // Glitch-free update: ch1 0x10 -> 0xF0 mid-period.
        p = n / 256 + 1;
        wait_n(p * 256 + 128);
        mem[0] = 16'h0000; mem[1] = 16'h0010; mem[2] = 16'h0000; mem[3] = 16'h0000;
        mem[4] = 16'h0001;
        wait_n((p + 2) * 256 + 128);
        mem[1] = 16'h00F0;
        wait_n((p + 3) * 256);
        count_period();
        check("glitch_ch1_old_width", cnt[1], 16);
        count_period();
        check("glitch_ch1_new_width", cnt[1], 240);

        // Reset during CAP of word 2: nothing from the aborted scan may commit.
        b = (n / 256 + 1) * 256;
        wait_n(b);
        repeat (5) step();
        check("midscan_busy_before", int'(busy1), 1);
        rst = 1'b1;
        step();
        check("midscan_busy", int'(busy1), 0);
        check("midscan_cs", int'(cs1), 0);
        check("midscan_led", int'(led1), 0);
        rst = 1'b0;
        wait_n(256);
        count_period();
        check("midscan_no_commit", cnt[0] + cnt[1] + cnt[2] + cnt[3], 0);
        count_period();
        check("midscan_first_commit", cnt[1], 240);

        // Random register traffic, checked by the model every cycle.
        for (int r = 0; r < 10; r++) begin
            p = n / 256 + 1;
            wait_n(p * 256 + 128);
            for (int i = 0; i < 5; i++) mem[i] = 16'($urandom);
        end
        wait_n(n + 600);

        check("p3_window_reached", int'(d3_done), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_pwm_scan.md
LED_PWM_SCAN -- requirements
Module: led_pwm_scan

Interface
Parameters:
REQ-001 The block SHALL expose parameter DATA_WIDTH, default 16: RAM word width.
REQ-002 The block SHALL expose parameter ADDR_WIDTH, default 4: RAM address width.
REQ-003 The block SHALL expose parameter BASE_ADDR, default 0: address of channel 0 duty word.
REQ-004 The block SHALL expose parameter PRESCALE, default 4: clk cycles per PWM tick, legal range 1..65535.

Ports:
REQ-005 The block SHALL have port clk, input, 1 bit: single system clock, all logic on rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port ram_cs, output, 1 bit: RAM port chip select, active-high.
REQ-008 The block SHALL have port ram_we, output, 1 bit: RAM port write enable, active-high, constant 0.
REQ-009 The block SHALL have port ram_oe, output, 1 bit: RAM port output enable, active-high.
REQ-010 The block SHALL have port ram_addr, output, ADDR_WIDTH bits: RAM read address.
REQ-011 The block SHALL have port ram_rdata, input, DATA_WIDTH bits: RAM read data.
REQ-012 The block SHALL have port led, output, 4 bits: PWM outputs, one per channel.
REQ-013 The block SHALL have port busy, output, 1 bit: high while a register scan is in progress.

Function
REQ-014 RAM protocol: a read SHALL be issued by driving ram_cs=1, ram_oe=1, ram_we=0 for exactly one cycle with ram_addr valid; ram_rdata SHALL be sampled at the end of the following cycle (1-cycle sync RAM latency); ram_cs=ram_oe=0 in all other cycles.
REQ-015 Register map read per scan: BASE_ADDR+0..+3 = duty ch0..ch3 (bits [7:0] used, upper bits ignored); BASE_ADDR+4 = control (bit0 enable, bit1 invert, other bits ignored); address arithmetic SHALL wrap modulo 2^ADDR_WIDTH.
REQ-016 Prescaler: counter 0..PRESCALE-1, tick pulse when counter == PRESCALE-1, then counter returns to 0.
REQ-017 PWM counter: 8 bits, increments on each tick, wraps 255->0; "period boundary" = tick on which it wraps to 0.
REQ-018 FSM states: IDLE, REQ, CAP. IDLE->REQ on period boundary; REQ (read strobe for word i) -> CAP; CAP captures ram_rdata into shadow[i], then -> REQ with i+1 if i<4, else -> IDLE and set pending.
REQ-019 A scan SHALL take exactly 10 cycles from the REQ entry to the IDLE return; busy=1 in REQ and CAP, 0 in IDLE.
REQ-020 Commit: on a period boundary with pending=1, active duty[0..3] and control SHALL load from shadow and pending SHALL clear; on the same edge a new scan SHALL start (commit uses the shadow from the previous scan).
REQ-021 Output: raw[i] = enable & (pwm_cnt < duty[i]); led[i] = raw[i] XOR invert; registered, one cycle after pwm_cnt/duty change.
REQ-022 Duty 0 SHALL give constant raw 0; duty 255 SHALL give raw high 255 of 256 ticks.
REQ-023 Active duty/control SHALL never change except at a period boundary (glitch-free PWM).

Reset
REQ-024 With rst=1 at a clock edge: FSM->IDLE, word index 0, prescaler 0, pwm_cnt 0, shadow/active duty 0, control 0, pending 0; led=4'b0000, busy=0, ram_cs=ram_oe=ram_we=0, ram_addr=BASE_ADDR.
REQ-025 Reset asserted mid-scan SHALL abort the scan with no commit; the first scan after reset starts at the first period boundary (256*PRESCALE cycles after release).

Verification
REQ-026 Reset mid-scan: assert rst during CAP of word 2 -> next cycle busy=0, ram_cs=0, led=0000, pending=0; no later commit of partial data.
REQ-027 Read timing: RAM model with 1-cycle latency, words 0x0040,0x0080,0x00C0,0x00FF, ctrl 0x0001, PRESCALE=1 -> ram_addr sequence 0..4 with ram_cs high 1 of every 2 cycles, busy high for 10 cycles.
REQ-028 Duty check: after the commit boundary, measure over 256 ticks -> led high counts 64,128,192,255.
REQ-029 Control: ctrl=0x0000 -> led=0000 after the commit; ctrl=0x0003 with duty ch0=0 -> led[0] constantly 1.
REQ-030 Glitch-free update: change RAM duty ch1 from 0x10 to 0xF0 mid-period -> led[1] keeps the 16-tick high width until the second period boundary after the change.
REQ-031 Masking/prescale: duty word 0xAB20, PRESCALE=3 -> high width 32 ticks = 96 clk per 768-clk period.
